// File: rtl/uart_tx_if.sv
// Upstream word handshake for the UART transmitter.
//
// Signals:
//   data  - parallel word to transmit, meaningful while valid=1
//   valid - upstream presents a word on data
//   ready - transmitter is idle and takes the word at this edge
//
// Modports:
//   master - the word source (drives data/valid, observes ready)
//   slave  - the transmitter (observes data/valid, drives ready)
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_tx.sv
// Serial UART transmitter paced by an external baud strobe.
//
// One word is taken per valid/ready handshake and sent LSB first as
// start bit, DATA_BITS data bits, optional parity bit, STOP_BITS stop bits.
// Every clk cycle with tick=1 ends one bit time on the line.
//
// Parameters:
//   DATA_BITS - data word width, 5..9
//   PARITY    - 0 none, 1 even, 2 odd
//   STOP_BITS - 1 or 2
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   tick  - one-cycle baud strobe from the clock divider
//   bus   - word handshake (slave side): data, valid in; ready out
//   busy  - frame in progress (always the inverse of bus.ready)
//   tx    - registered serial line, idles high
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     tick,
    uart_tx_if.slave bus,
    output logic     busy,
    output logic     tx
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam int                CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 stop_cnt;

    // Even parity is the XOR of the word; odd parity inverts it.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
        logic odd;
        odd = (PARITY == 2);
        return (^word) ^ odd;
    endfunction

    assign bus.ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // The shift register and parity bit carry data only; they are loaded
    // on acceptance and need no reset value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (bus.valid) begin
                        shreg    <= bus.data;
                        par_bit  <= parity_of(bus.data);
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        state    <= S_ALIGN;
                    end
                end

                // A tick in the acceptance cycle was seen in IDLE and
                // ignored, so the first tick here opens a full-length
                // start bit.
                S_ALIGN: begin
                    if (tick) begin
                        tx    <= 1'b0;
                        state <= S_START;
                    end
                end

                S_START: begin
                    if (tick) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= CNT_W'(1);
                        state   <= S_DATA;
                    end
                end

                // bit_cnt counts data bits already placed on the line.
                S_DATA: begin
                    if (tick) begin
                        if (bit_cnt < LAST_BIT) begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (PARITY != 0) begin
                            tx    <= par_bit;
                            state <= S_PARITY;
                        end else begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end
                    end
                end

                S_PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end
                end

                S_STOP: begin
                    tx <= 1'b1;
                    if (tick) begin
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five parameterisations side by side, each with a
// tick-counting frame model, plus directed frames for the listed cases.
module tb_uart_tx;

    localparam int N = 5;
    localparam int DBS  [N] = '{8, 8, 8, 5, 9};
    localparam int PARS [N] = '{0, 1, 2, 1, 0};
    localparam int SBS  [N] = '{1, 1, 2, 2, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         tick;
    logic [8:0]   data_v  [N];
    logic         valid_v [N];
    logic [N-1:0] tx_w;
    logic [N-1:0] ready_w;
    logic [N-1:0] busy_w;
    int           tick_period = 4;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_if #(.DATA_BITS(8)) ifc0 ();
    uart_tx_if #(.DATA_BITS(8)) ifc1 ();
    uart_tx_if #(.DATA_BITS(8)) ifc2 ();
    uart_tx_if #(.DATA_BITS(5)) ifc3 ();
    uart_tx_if #(.DATA_BITS(9)) ifc4 ();

    assign ifc0.data = data_v[0][7:0];  assign ifc0.valid = valid_v[0];  assign ready_w[0] = ifc0.ready;
    assign ifc1.data = data_v[1][7:0];  assign ifc1.valid = valid_v[1];  assign ready_w[1] = ifc1.ready;
    assign ifc2.data = data_v[2][7:0];  assign ifc2.valid = valid_v[2];  assign ready_w[2] = ifc2.ready;
    assign ifc3.data = data_v[3][4:0];  assign ifc3.valid = valid_v[3];  assign ready_w[3] = ifc3.ready;
    assign ifc4.data = data_v[4];       assign ifc4.valid = valid_v[4];  assign ready_w[4] = ifc4.ready;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .bus(ifc0), .busy(busy_w[0]), .tx(tx_w[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .bus(ifc1), .busy(busy_w[1]), .tx(tx_w[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .bus(ifc2), .busy(busy_w[2]), .tx(tx_w[2]));
    uart_tx #(.DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .bus(ifc3), .busy(busy_w[3]), .tx(tx_w[3]));
    uart_tx #(.DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .bus(ifc4), .busy(busy_w[4]), .tx(tx_w[4]));

    task automatic check(input string tag, input int id, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s[dut%0d] at %0t: got %0h, expected %0h", tag, id, $time, got, exp);
        else
            n_pass++;
    endtask

    // Frame as a list of bit times: index 0 start, then data LSB first,
    // then parity if enabled, then stop bits.
    function automatic int flen(input int i);
        return 1 + DBS[i] + ((PARS[i] != 0) ? 1 : 0) + SBS[i];
    endfunction

    function automatic logic fbit(input int i, input logic [8:0] w, input int k);
        logic p;
        p = 1'b0;
        if (k == 0) return 1'b0;
        if (k <= DBS[i]) return w[k-1];
        if (PARS[i] != 0 && k == DBS[i] + 1) begin
            for (int j = 0; j < DBS[i]; j++) p = p ^ w[j];
            return (PARS[i] == 2) ? ~p : p;
        end
        return 1'b1;
    endfunction

    // Reference: after acceptance, the k-th tick puts frame bit k-1 on the
    // line; the tick after the last bit returns the block to idle.
    logic [N-1:0] busy_m;
    logic [N-1:0] tx_e;
    int           tcnt [N];
    logic [8:0]   wd   [N];
    bit           armed = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) armed <= 1'b1;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                busy_m[i] <= 1'b0;
                tx_e[i]   <= 1'b1;
                tcnt[i]   <= 0;
            end else if (!busy_m[i]) begin
                if (valid_v[i]) begin
                    busy_m[i] <= 1'b1;
                    tcnt[i]   <= 0;
                    wd[i]     <= data_v[i];
                end
            end else if (tick) begin
                if (tcnt[i] < flen(i)) begin
                    tx_e[i] <= fbit(i, wd[i], tcnt[i]);
                    tcnt[i] <= tcnt[i] + 1;
                end else begin
                    busy_m[i] <= 1'b0;
                    tx_e[i]   <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < N; i++) begin
                check("tx", i, 32'(tx_w[i]), 32'(tx_e[i]));
                check("ready", i, 32'(ready_w[i]), 32'(!busy_m[i]));
                check("busy", i, 32'(busy_w[i]), 32'(busy_m[i]));
            end
        end
    end

    initial begin : tick_gen
        int tc;
        tc   = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tc >= tick_period - 1) begin
                tick = 1'b1;
                tc   = 0;
            end else begin
                tick = 1'b0;
                tc++;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_tick_edge(input int id, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("tick_timeout", id, 32'd0, 32'd1);
    endtask

    // Samples tx once per tick for n ticks; bit k of bits is the line
    // value after the (k+1)-th tick.
    task automatic cap(input int id, input int n, output logic [31:0] bits);
        bit ok;
        bits = '0;
        for (int k = 0; k < n; k++) begin
            wait_tick_edge(id, ok);
            if (!ok) return;
            @(negedge clk);
            bits[k] = tx_w[id];
        end
    endtask

    // Presents w and returns 2 time units after the accepting edge.
    task automatic offer(input int id, input logic [8:0] w, input bit align, input bit keep);
        bit r;
        bit done;
        @(posedge clk);
        #2;
        if (align) begin
            for (int c = 0; c < 200 && !tick; c++) begin
                @(posedge clk);
                #2;
            end
        end
        data_v[id]  = w;
        valid_v[id] = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            r = ready_w[id];
            @(posedge clk);
            #2;
            done = r;
        end
        if (!done) check("accept_timeout", id, 32'd0, 32'd1);
        if (!keep) valid_v[id] = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int c;
        c = 0;
        while (busy_m[id] && c < 3000) begin
            @(posedge clk);
            c++;
        end
        if (busy_m[id]) check("idle_timeout", id, 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : main
        logic [31:0] b;
        logic [31:0] b2;
        int          n;
        bit          ok;
        int          a;
        int          c;

        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            valid_v[i] = 1'b0;
            data_v[i]  = '0;
        end

        // Reset values, then an idle line with ticks running.
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_tx", i, 32'(tx_w[i]), 32'd1);
            check("rst_ready", i, 32'(ready_w[i]), 32'd1);
            check("rst_busy", i, 32'(busy_w[i]), 32'd0);
        end
        repeat (50) @(posedge clk);

        // 8N1 frame of 0xA5: line per tick 0,1,0,1,0,0,1,0,1,1.
        offer(0, 9'h0A5, 1'b0, 1'b0);
        cap(0, 10, b);
        check("frame_8n1", 0, b & 32'h3FF, 32'h34A);
        wait_tick_edge(0, ok);
        @(negedge clk);
        check("ready_after_8n1", 0, 32'(ready_w[0]), 32'd1);

        // Even parity, one stop bit: 11 bit times, parity bit 0.
        offer(1, 9'h0A5, 1'b0, 1'b0);
        cap(1, 11, b);
        check("frame_8e1", 1, b & 32'h7FF, 32'h54A);
        check("parity_even", 1, 32'(b[9]), 32'd0);
        wait_tick_edge(1, ok);
        @(negedge clk);
        check("ready_after_8e1", 1, 32'(ready_w[1]), 32'd1);

        // Odd parity, two stop bits: 12 bit times, parity bit 1.
        offer(2, 9'h0A5, 1'b0, 1'b0);
        cap(2, 12, b);
        check("frame_8o2", 2, b & 32'hFFF, 32'hF4A);
        check("parity_odd", 2, 32'(b[9]), 32'd1);
        wait_tick_edge(2, ok);
        @(negedge clk);
        check("ready_after_8o2", 2, 32'(ready_w[2]), 32'd1);

        // Word offered on a tick cycle: that tick does not start the frame,
        // and the start bit lasts one full interval.
        offer(0, 9'(($urandom & 32'hFF) | 32'h1), 1'b1, 1'b0);
        check("align_tx_high", 0, 32'(tx_w[0]), 32'd1);
        wait_tick_edge(0, ok);
        @(negedge clk);
        check("align_start", 0, 32'(tx_w[0]), 32'd0);
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_w[0] != 1'b0) break;
            n++;
        end
        check("start_len", 0, 32'(n), 32'(tick_period));
        wait_idle(0);

        // Back-to-back with valid held: 0x00, then 0xFF; data changes
        // mid-frame. Expect a one-tick idle-high gap between frames.
        offer(0, 9'h000, 1'b0, 1'b1);
        data_v[0] = 9'h0FF;
        cap(0, 11, b);
        check("b2b_first", 0, b & 32'h7FF, 32'h600);
        check("b2b_ready", 0, 32'(ready_w[0]), 32'd1);
        cap(0, 10, b2);
        valid_v[0] = 1'b0;
        check("b2b_second", 0, b2 & 32'h3FF, 32'h3FE);
        wait_idle(0);

        // Reset during data bit 3, then a clean frame.
        offer(0, 9'h0A5, 1'b0, 1'b0);
        cap(0, 5, b);
        check("pre_reset_bits", 0, b & 32'h1F, 32'h0A);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_tx", 0, 32'(tx_w[0]), 32'd1);
        check("midrst_ready", 0, 32'(ready_w[0]), 32'd1);
        offer(0, 9'h0A5, 1'b0, 1'b0);
        cap(0, 10, b);
        check("post_reset_frame", 0, b & 32'h3FF, 32'h34A);
        wait_idle(0);

        // Randomised frames on pairs of transmitters, random tick spacing,
        // alignment, mid-frame data changes and occasional resets.
        for (int it = 0; it < 40; it++) begin
            tick_period = $urandom_range(1, 6);
            a = $urandom_range(0, N - 1);
            c = (a + $urandom_range(1, N - 1)) % N;
            fork
                begin
                    offer(a, 9'($urandom), 1'($urandom), 1'b0);
                    if ($urandom_range(0, 1) == 1) data_v[a] = 9'($urandom);
                end
                begin
                    offer(c, 9'($urandom), 1'($urandom), 1'b0);
                    if ($urandom_range(0, 1) == 1) data_v[c] = 9'($urandom);
                end
            join
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 30)) @(posedge clk);
                pulse_reset();
            end
            wait_idle(a);
            wait_idle(c);
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter driven by an external baud strobe. It sits directly downstream of the clock divider: the divider's one-cycle `out` pulse connects to `tick`, and each tick interval is one bit time on the line. It accepts one parallel word per valid/ready handshake. It emits an LSB-first frame: start bit, data, optional parity, stop bits.

## Interface
- `DATA_BITS`, default 8: data word width; legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.

- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `tick`  input  1  baud strobe, one `clk` cycle wide (the clock divider's `out`); each cycle with `tick`=1 counts as one tick.
- `data`  input  DATA_BITS  word to send; sampled only on acceptance.
- `valid`  input  1  upstream has a word on `data`.
- `ready`  output  1  block is idle and can accept a word.
- `busy`  output  1  frame in progress; always `!ready`.
- `tx`  output  1  serial line, registered; idle level 1.

## Operation
- States: IDLE, ALIGN, START, DATA, PARITY, STOP.
- Reset (`rst_n`=0 at a rising edge) puts the block in IDLE, with `tx`=1, `ready`=1, `busy`=0, and bit and stop counters at 0.
- IDLE:
  - `ready`=1 and `tx`=1; `tick` is ignored.
  - Acceptance happens when `valid`=1 and `ready`=1 at the same edge. At that edge, `data` is latched into a shift register and the parity bit is computed from the latched word.
  - Next state is ALIGN.
- ALIGN:
  - Waits for the first `tick` strictly after the acceptance cycle.
  - On that tick: next state is START and `tx`<=0.
  - This guarantees the start bit lasts a full tick interval.
- START: on tick, `tx`<=data bit 0, next state DATA, bit counter <=1.
- DATA:
  - On tick, if bit counter < DATA_BITS: `tx`<=next LSB-first bit and the counter increments.
  - Otherwise, next state is PARITY if `PARITY`≠0; it is STOP if `PARITY`=0.
  - On entering PARITY, `tx`<=parity bit. On entering STOP, `tx`<=1.
- PARITY:
  - Even parity: the parity bit is the XOR of the data bits. Odd parity: it is the inverse of that XOR.
  - On tick, `tx`<=1 and next state is STOP.
- STOP:
  - `tx`=1. Each tick counts one stop bit.
  - On the tick that ends stop bit STOP_BITS, next state is IDLE and `ready`=1 from the next cycle.
- Frame length: 1 + DATA_BITS + (PARITY≠0) + STOP_BITS tick intervals.
- `data` changes after acceptance have no effect on the frame in flight.
- `valid` while `ready`=0 is ignored; no word is lost or queued, and upstream must hold `valid`.
- Illegal parameter values are a synthesis/elaboration error.

## Timing
- All outputs are registered. `ready` and `busy` are decoded from the state register.
- `tx` changes exactly one `clk` cycle after the rising edge where `tick`=1 is sampled.
- Acceptance latency: `ready` falls the cycle after the accepting edge.
- Start-bit latency: `tx` falls one cycle after the first tick that occurs after acceptance. A tick in the acceptance cycle itself does not count.
- Back-to-back frames:
  - The earliest next acceptance is the cycle after return to IDLE.
  - Its start bit begins one cycle after the next tick following that acceptance.
  - With a continuously asserted `valid`, this yields a one-tick idle gap between frames.
- `tick`=1 on every cycle is legal; each bit then lasts one `clk` cycle.
- Reset mid-frame: on the edge with `rst_n`=0, the frame is abandoned. `tx`=1 and `ready`=1 from the next cycle; no partial stop bit is owed.
- Reset has priority over `tick` and handshake in the same cycle.

## Test plan
- Reset values: hold `rst_n`=0 for 3 cycles, then release. Required: `tx`=1, `ready`=1, `busy`=0, and `tx` stays 1 for 50 cycles with `valid`=0 and ticks running.
- 8N1 frame: `tick` every 4 cycles, send 0xA5 (all parameters default). Required: `tx` sequence per tick 0,1,0,1,0,0,1,0,1,1. That is 10 bit times of exactly 4 cycles each; `ready` returns after the stop bit.
- Parity frames: send 0xA5 with `PARITY`=1, then with `PARITY`=2, `STOP_BITS`=2. Required for `PARITY`=1: parity bit 0, followed by one stop bit. Required for `PARITY`=2: parity bit 1, followed by 2 stop ticks of 1; total 11 and 12 bit times respectively.
- Alignment: assert `valid` on the same cycle as a `tick` in IDLE. Required: that tick is not used. `tx` falls one cycle after the next tick, and the start bit lasts a full interval.
- Backpressure and back-to-back: hold `valid`=1 with words 0x00 then 0xFF. Required: the second word is accepted only after the first stop bit completes, and `data` changes mid-frame do not corrupt the first frame. Bits are all-0 data then all-1 data, with a one-tick idle-high gap between frames.
- Reset mid-frame: assert `rst_n`=0 during data bit 3. Required: `tx`=1 and `ready`=1 the next cycle. A new word sent afterwards produces a complete, correct frame.
